alu_sequencer: RTL

//  Multi-cycle controller for the 8-bit ALU datapath. Accepts one instruction per valid/ready handshake,

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_sequencer_if.sv | 36 +++
 rtl/alu_sequencer_reg_file.sv | 30 +++
 rtl/alu_sequencer.sv | 109 ++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU sequencer: opcodes, ALU controls,
// flag bit positions and controller states.
package alu_pkg;
  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_ADDI = 3'b100
  } op_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  localparam int FLG_N = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_t;

  function automatic logic is_legal(input logic [2:0] op);
    return op <= OP_ADDI;
  endfunction
endpackage

// File: rtl/alu_sequencer_if.sv
// Instruction, ALU and debug signals between the sequencer and its neighbours.
interface alu_sequencer_if #(
  parameter int NREGS = 8,
  parameter int DW    = 8
);
  localparam int AW = $clog2(NREGS);

  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_op;
  logic [AW-1:0] in_rd;
  logic [AW-1:0] in_ra;
  logic [AW-1:0] in_rb;
  logic [DW-1:0] in_imm;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [1:0]    alu_ctrl;
  logic [DW-1:0] alu_y;
  logic [3:0]    alu_flags;
  logic          done;
  logic          err;
  logic [DW-1:0] result;
  logic [3:0]    flags;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_data;

  modport master (
    output in_valid, in_op, in_rd, in_ra, in_rb, in_imm, alu_y, alu_flags, dbg_addr,
    input  in_ready, alu_a, alu_b, alu_ctrl, done, err, result, flags, dbg_data
  );

  modport slave (
    input  in_valid, in_op, in_rd, in_ra, in_rb, in_imm, alu_y, alu_flags, dbg_addr,
    output in_ready, alu_a, alu_b, alu_ctrl, done, err, result, flags, dbg_data
  );
endinterface

// File: rtl/alu_sequencer_reg_file.sv
// NREGS x DW register file: two operand read ports, one debug read port,
// one synchronous write port, cleared asynchronously on reset.
module reg_file #(
  parameter int NREGS = 8,
  parameter int DW    = 8,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr_a,
  output logic [DW-1:0] rdata_a,
  input  logic [AW-1:0] raddr_b,
  output logic [DW-1:0] rdata_b,
  input  logic [AW-1:0] raddr_d,
  output logic [DW-1:0] rdata_d
);
  logic [NREGS-1:0][DW-1:0] mem;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) mem <= '0;
    else if (we)  mem[waddr] <= wdata;
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];
  assign rdata_d = mem[raddr_d];
endmodule

// File: rtl/alu_sequencer.sv
// Four-state controller (IDLE/READ/EXEC/WB) that reads operands, drives the
// external ALU, captures its result and flags, and writes them back.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int NREGS = 8,
  parameter int DW    = 8
) (
  input logic            clk,
  input logic            reset_n,
  alu_sequencer_if.slave bus
);
  localparam int AW = $clog2(NREGS);

  state_t        state;
  logic [2:0]    op_q;
  logic [AW-1:0] rd_q, ra_q, rb_q;
  logic [DW-1:0] imm_q, y_q, result_q, alu_a_q, alu_b_q;
  logic [3:0]    flg_q, flags_q;
  logic [1:0]    ctrl_q;
  logic          ready_q, done_q, err_q;
  logic [DW-1:0] rdata_a, rdata_b, op_b;
  logic          legal, we;

  assign legal = is_legal(op_q);
  assign op_b  = (op_q == OP_ADDI) ? imm_q : rdata_b;
  assign we    = (state == S_WB) && legal;

  reg_file #(.NREGS(NREGS), .DW(DW), .AW(AW)) u_rf (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (we),
    .waddr   (rd_q),
    .wdata   (y_q),
    .raddr_a (ra_q),
    .rdata_a (rdata_a),
    .raddr_b (rb_q),
    .rdata_b (rdata_b),
    .raddr_d (bus.dbg_addr),
    .rdata_d (bus.dbg_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      op_q     <= '0;
      rd_q     <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      imm_q    <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      ctrl_q   <= ALU_ADD;
      y_q      <= '0;
      flg_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        S_IDLE: if (bus.in_valid) begin
          op_q    <= bus.in_op;
          rd_q    <= bus.in_rd;
          ra_q    <= bus.in_ra;
          rb_q    <= bus.in_rb;
          imm_q   <= bus.in_imm;
          ready_q <= 1'b0;
          state   <= S_READ;
        end
        S_READ: begin
          // addi (100) maps onto the add control through its low bits
          alu_a_q <= rdata_a;
          alu_b_q <= op_b;
          ctrl_q  <= op_q[1:0];
          state   <= S_EXEC;
        end
        S_EXEC: begin
          y_q    <= bus.alu_y;
          flg_q  <= bus.alu_flags;
          done_q <= legal;
          err_q  <= !legal;
          state  <= S_WB;
        end
        S_WB: begin
          if (legal) begin
            result_q <= y_q;
            flags_q  <= flg_q;
          end
          ready_q <= 1'b1;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready = ready_q;
  assign bus.alu_a    = alu_a_q;
  assign bus.alu_b    = alu_b_q;
  assign bus.alu_ctrl = ctrl_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.result   = result_q;
  assign bus.flags    = flags_q;
endmodule
